// File: rtl/bin2bcd_seq_gen.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Generic input width N, D output digits, and an optional two's-complement mode
// in which the magnitude is converted and the sign is reported separately.
// Results are held in output registers and change only when done pulses.
module bin2bcd_seq_gen #(
   parameter int N      = 16,
   parameter int D      = 5,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N-1:0]     in_data,
   output logic [4*D-1:0]   bcd,
   output logic             neg,
   output logic             ovf,
   output logic             ready,
   output logic             done
);

   // Number of bits needed to count down from N-1 to 0.
   function automatic int clog2_f(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   localparam int CW = clog2_f(N);
   localparam int DW = 4 * D;

   // Add 3 to every digit that is 5 or more, so the next left shift carries
   // correctly into the neighbouring decimal digit.
   function automatic logic [DW-1:0] add3_f(input logic [DW-1:0] w);
      logic [DW-1:0] r;
      r = w;
      for (int k = 0; k < D; k++) begin
         if (w[4*k +: 4] >= 4'd5) begin
            r[4*k +: 4] = w[4*k +: 4] + 4'd3;
         end else begin
            r[4*k +: 4] = w[4*k +: 4];
         end
      end
      return r;
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state_r;
   logic [N-1:0]    sr_r;
   logic [DW-1:0]   w_r;
   logic [CW-1:0]   cnt_r;
   logic            sign_r;
   logic            ovf_int_r;

   logic [DW-1:0]   adj_s;
   logic [DW-1:0]   w_next_s;
   logic [N-1:0]    sr_next_s;
   logic            ovf_next_s;
   logic            neg_in_s;
   logic [N-1:0]    mag_s;

   // Per-cycle datapath: adjust digits, shift {w,sr} left, track lost bits,
   // and form the magnitude/sign of the operand offered on in_data.
   always_comb begin
      adj_s      = add3_f(w_r);
      w_next_s   = {adj_s[DW-2:0], sr_r[N-1]};
      sr_next_s  = {sr_r[N-2:0], 1'b0};
      ovf_next_s = ovf_int_r | adj_s[DW-1];
      if ((SIGNED != 0) && in_data[N-1]) begin
         neg_in_s = 1'b1;
         mag_s    = ~in_data + N'(1);
      end else begin
         neg_in_s = 1'b0;
         mag_s    = in_data;
      end
   end

   // Control FSM with working registers; results are latched on the last
   // shift so they are already valid during the done cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= IDLE;
         sr_r      <= '0;
         w_r       <= '0;
         cnt_r     <= '0;
         sign_r    <= 1'b0;
         ovf_int_r <= 1'b0;
         bcd       <= '0;
         neg       <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  sr_r      <= mag_s;
                  sign_r    <= neg_in_s;
                  w_r       <= '0;
                  ovf_int_r <= 1'b0;
                  cnt_r     <= CW'(N - 1);
                  state_r   <= SHIFT;
               end else begin
                  state_r   <= IDLE;
               end
            end
            SHIFT: begin
               w_r       <= w_next_s;
               sr_r      <= sr_next_s;
               ovf_int_r <= ovf_next_s;
               cnt_r     <= cnt_r - CW'(1);
               if (cnt_r == '0) begin
                  bcd     <= w_next_s;
                  ovf     <= ovf_next_s;
                  neg     <= sign_r;
                  state_r <= DONE;
               end else begin
                  state_r <= SHIFT;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign ready = (state_r == IDLE);
   assign done  = (state_r == DONE);

endmodule
